riscv_v_exe_seq: RTL and testbench

Micro-op sequencer in front of the vector execute ALU. It accepts one vector instruction at a time with a register-group multiplier (LMUL 1/2/4/8). It breaks the instruction into one ALU pass per register of the group, stepping the destination and source register indices each pass. For reductions it chains passes through an accumulator-forward flag, so only the final pass writes back. It sits between vector decode/issue and the exe ALU/register-file read stage.

---
 rtl/riscv_v_exe_seq.sv | 187 ++++++++++++++++++
 tb/tb_riscv_v_exe_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_exe_seq.sv
// Vector execute micro-op sequencer: splits one LMUL-grouped instruction into per-register ALU passes.
// Optional RISCV_V_SEQ_PERF_EN adds saturating busy/stall performance counters.
module riscv_v_exe_seq #(
  parameter int unsigned CTRL_W    = 64,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_vd,
  input  logic [REG_IDX_W-1:0] in_vs1,
  input  logic [REG_IDX_W-1:0] in_vs2,
  input  logic [1:0]           in_lmul_log2,
  input  logic                 in_is_reduct,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 flush,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic [REG_IDX_W-1:0] uop_vd,
  output logic [REG_IDX_W-1:0] uop_vs1,
  output logic [REG_IDX_W-1:0] uop_vs2,
  output logic [CTRL_W-1:0]    uop_ctrl,
  output logic [2:0]           uop_idx,
  output logic                 uop_first,
  output logic                 uop_last,
  output logic                 uop_acc_fwd,
  output logic                 uop_wb_en,
  output logic                 done,
`ifdef RISCV_V_SEQ_PERF_EN
  output logic                 illegal,
  output logic [31:0]          perf_busy_cnt,
  output logic [31:0]          perf_stall_cnt
`else
  output logic                 illegal
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state;
  logic [1:0]           r_lmul_log2;
  logic                 r_is_reduct;
  logic                 r_uop_valid;
  logic [REG_IDX_W-1:0] r_uop_vd;
  logic [REG_IDX_W-1:0] r_uop_vs1;
  logic [REG_IDX_W-1:0] r_uop_vs2;
  logic [CTRL_W-1:0]    r_uop_ctrl;
  logic [2:0]           r_idx;
  logic                 r_uop_first;
  logic                 r_uop_last;
  logic                 r_uop_acc_fwd;
  logic                 r_uop_wb_en;
  logic                 r_done;
  logic                 r_illegal;

  logic [REG_IDX_W-1:0] w_align_mask;
  logic                 w_misaligned;
  logic                 w_accept;
  logic                 w_hs;
  logic                 w_in_single;
  logic [2:0]           w_last_idx;
  logic [2:0]           w_idx_nxt;
  logic                 w_nxt_is_last;
  logic [REG_IDX_W-1:0] w_grp_step;

  assign in_ready = (r_state == S_IDLE);

  assign w_align_mask = REG_IDX_W'((32'd1 << in_lmul_log2) - 32'd1);
  // Reductions read vs1 as a single scalar register, so only vd and vs2 must be group-aligned.
  assign w_misaligned = (|(in_vd & w_align_mask)) | (|(in_vs2 & w_align_mask))
                      | (~in_is_reduct & (|(in_vs1 & w_align_mask)));
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_in_single  = (in_lmul_log2 == 2'd0);

  assign w_hs          = r_uop_valid & uop_ready;
  assign w_last_idx    = 3'((4'd1 << r_lmul_log2) - 4'd1);
  assign w_idx_nxt     = r_idx + 3'd1;
  assign w_nxt_is_last = (w_idx_nxt == w_last_idx);
  assign w_grp_step    = {{(REG_IDX_W-1){1'b0}}, ~r_is_reduct};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lmul_log2   <= '0;
      r_is_reduct   <= 1'b0;
      r_uop_valid   <= 1'b0;
      r_uop_vd      <= '0;
      r_uop_vs1     <= '0;
      r_uop_vs2     <= '0;
      r_uop_ctrl    <= '0;
      r_idx         <= '0;
      r_uop_first   <= 1'b0;
      r_uop_last    <= 1'b0;
      r_uop_acc_fwd <= 1'b0;
      r_uop_wb_en   <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (flush) begin
        r_state     <= S_IDLE;
        r_uop_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (w_misaligned) begin
                r_illegal <= 1'b1;
              end else begin
                r_state       <= S_RUN;
                r_lmul_log2   <= in_lmul_log2;
                r_is_reduct   <= in_is_reduct;
                r_uop_valid   <= 1'b1;
                r_uop_vd      <= in_vd;
                r_uop_vs1     <= in_vs1;
                r_uop_vs2     <= in_vs2;
                r_uop_ctrl    <= in_ctrl;
                r_idx         <= '0;
                r_uop_first   <= 1'b1;
                r_uop_last    <= w_in_single;
                r_uop_acc_fwd <= 1'b0;
                r_uop_wb_en   <= ~in_is_reduct | w_in_single;
              end
            end
          end
          S_RUN: begin
            if (w_hs) begin
              if (r_uop_last) begin
                r_state     <= S_IDLE;
                r_uop_valid <= 1'b0;
                r_done      <= 1'b1;
              end else begin
                // Register indices advance incrementally; reductions keep vd/vs1 fixed.
                r_idx         <= w_idx_nxt;
                r_uop_vd      <= r_uop_vd + w_grp_step;
                r_uop_vs1     <= r_uop_vs1 + w_grp_step;
                r_uop_vs2     <= r_uop_vs2 + {{(REG_IDX_W-1){1'b0}}, 1'b1};
                r_uop_first   <= 1'b0;
                r_uop_last    <= w_nxt_is_last;
                r_uop_acc_fwd <= r_is_reduct;
                r_uop_wb_en   <= ~r_is_reduct | w_nxt_is_last;
              end
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_uop_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uop_valid   = r_uop_valid;
  assign uop_vd      = r_uop_vd;
  assign uop_vs1     = r_uop_vs1;
  assign uop_vs2     = r_uop_vs2;
  assign uop_ctrl    = r_uop_ctrl;
  assign uop_idx     = r_idx;
  assign uop_first   = r_uop_first;
  assign uop_last    = r_uop_last;
  assign uop_acc_fwd = r_uop_acc_fwd;
  assign uop_wb_en   = r_uop_wb_en;
  assign done        = r_done;
  assign illegal     = r_illegal;

`ifdef RISCV_V_SEQ_PERF_EN
  logic [31:0] r_busy_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (~&r_busy_cnt) r_busy_cnt <= r_busy_cnt + 32'd1;
      if (~uop_ready && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_busy_cnt  = r_busy_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_v_exe_seq.sv
// Directed self-checking bench for riscv_v_exe_seq (honours RISCV_V_SEQ_PERF_EN when defined).
module tb_riscv_v_exe_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_vd, in_vs1, in_vs2;
  logic [1:0]  in_lmul_log2;
  logic        in_is_reduct;
  logic [63:0] in_ctrl;
  logic        flush;
  logic        uop_valid;
  logic        uop_ready;
  logic [4:0]  uop_vd, uop_vs1, uop_vs2;
  logic [63:0] uop_ctrl;
  logic [2:0]  uop_idx;
  logic        uop_first, uop_last, uop_acc_fwd, uop_wb_en;
  logic        done, illegal;
`ifdef RISCV_V_SEQ_PERF_EN
  logic [31:0] perf_busy_cnt, perf_stall_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned hs_cnt = 0;
  int unsigned hs_snap;

  riscv_v_exe_seq #(.CTRL_W(64), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_lmul_log2(in_lmul_log2), .in_is_reduct(in_is_reduct), .in_ctrl(in_ctrl),
    .flush(flush),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
    .uop_ctrl(uop_ctrl), .uop_idx(uop_idx),
    .uop_first(uop_first), .uop_last(uop_last),
    .uop_acc_fwd(uop_acc_fwd), .uop_wb_en(uop_wb_en),
    .done(done),
`ifdef RISCV_V_SEQ_PERF_EN
    .illegal(illegal),
    .perf_busy_cnt(perf_busy_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`else
    .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (uop_valid && uop_ready) hs_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pass(input string tag, input int unsigned vd, input int unsigned vs1,
                          input int unsigned vs2, input int unsigned idx, input logic first,
                          input logic last, input logic acc, input logic wb);
    chk({tag, ".valid"}, 64'(uop_valid), 64'd1);
    chk({tag, ".idx"},   64'(uop_idx),   64'(idx));
    chk({tag, ".vd"},    64'(uop_vd),    64'(vd));
    chk({tag, ".vs1"},   64'(uop_vs1),   64'(vs1));
    chk({tag, ".vs2"},   64'(uop_vs2),   64'(vs2));
    chk({tag, ".first"}, 64'(uop_first), 64'(first));
    chk({tag, ".last"},  64'(uop_last),  64'(last));
    chk({tag, ".acc"},   64'(uop_acc_fwd), 64'(acc));
    chk({tag, ".wb"},    64'(uop_wb_en), 64'(wb));
    chk({tag, ".done"},  64'(done),      64'd0);
  endtask

  task automatic offer(input int unsigned vd, input int unsigned vs1, input int unsigned vs2,
                       input int unsigned lmul_log2, input logic red, input logic [63:0] ctrl);
    in_valid     = 1'b1;
    in_vd        = 5'(vd);
    in_vs1       = 5'(vs1);
    in_vs2       = 5'(vs2);
    in_lmul_log2 = 2'(lmul_log2);
    in_is_reduct = red;
    in_ctrl      = ctrl;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vd = '0; in_vs1 = '0; in_vs2 = '0;
    in_lmul_log2 = '0; in_is_reduct = 1'b0; in_ctrl = '0; flush = 1'b0; uop_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.valid",    64'(uop_valid), 64'd0);
    chk("rst.vd",       64'(uop_vd), 64'd0);
    chk("rst.idx",      64'(uop_idx), 64'd0);
    chk("rst.ctrl",     uop_ctrl, 64'd0);
    chk("rst.done",     64'(done), 64'd0);
    chk("rst.illegal",  64'(illegal), 64'd0);

    // Non-reduction LMUL=4, vd=8 vs1=16 vs2=24
    offer(8, 16, 24, 2, 1'b0, 64'hDEAD_BEEF_0123_4567);
    tick();
    in_valid = 1'b0;
    chk("A.in_ready_busy", 64'(in_ready), 64'd0);
    chk("A.ctrl", uop_ctrl, 64'hDEAD_BEEF_0123_4567);
    for (int p = 0; p < 4; p++) begin
      chk_pass($sformatf("A.p%0d", p), 8 + p, 16 + p, 24 + p, p, p == 0, p == 3, 1'b0, 1'b1);
      tick();
    end
    chk("A.done", 64'(done), 64'd1);
    chk("A.valid_off", 64'(uop_valid), 64'd0);
    chk("A.in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("A.done_pulse", 64'(done), 64'd0);

    // Reduction with vd not group-aligned is still rejected
    offer(3, 5, 0, 3, 1'b1, 64'h11);
    tick();
    in_valid = 1'b0;
    chk("R0.illegal", 64'(illegal), 64'd1);
    chk("R0.valid", 64'(uop_valid), 64'd0);
    tick();
    chk("R0.illegal_pulse", 64'(illegal), 64'd0);

    // Reduction LMUL=8, vd=8 vs1=5 (scalar, unaligned allowed) vs2=0
    offer(8, 5, 0, 3, 1'b1, 64'h0000_0000_CAFE_F00D);
    tick();
    in_valid = 1'b0;
    for (int p = 0; p < 8; p++) begin
      chk_pass($sformatf("B.p%0d", p), 8, 5, p, p, p == 0, p == 7, p != 0, p == 7);
      tick();
    end
    chk("B.done", 64'(done), 64'd1);
    tick();

    // Backpressure: LMUL=2, ready low for 3 cycles on pass 0
    uop_ready = 1'b0;
    offer(2, 4, 6, 1, 1'b0, 64'h22);
    tick();
    in_valid = 1'b0;
    hs_snap = hs_cnt;
    for (int s = 0; s < 3; s++) begin
      chk_pass($sformatf("C.stall%0d", s), 2, 4, 6, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    uop_ready = 1'b1;
    tick();
    chk_pass("C.p1", 3, 5, 7, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("C.done", 64'(done), 64'd1);
    chk("C.handshakes", 64'(hs_cnt - hs_snap), 64'd2);
    tick();

    // Misaligned non-reduction: vd=3 with LMUL=2, and vs1=5 with LMUL=2
    offer(3, 4, 6, 1, 1'b0, 64'h33);
    tick();
    in_valid = 1'b0;
    chk("D.illegal", 64'(illegal), 64'd1);
    chk("D.valid", 64'(uop_valid), 64'd0);
    chk("D.in_ready", 64'(in_ready), 64'd1);
    chk("D.done", 64'(done), 64'd0);
    offer(4, 5, 6, 1, 1'b0, 64'h34);
    tick();
    in_valid = 1'b0;
    chk("D.illegal_vs1", 64'(illegal), 64'd1);
    tick();
    chk("D.illegal_clr", 64'(illegal), 64'd0);
    chk("D.valid2", 64'(uop_valid), 64'd0);

    // Next instruction accepted normally: LMUL=1 reduction, single pass
    offer(3, 7, 9, 0, 1'b1, 64'h44);
    tick();
    in_valid = 1'b0;
    chk_pass("E.single", 3, 7, 9, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("E.done", 64'(done), 64'd1);
    tick();

    // Flush during pass 2 of LMUL=8, then flush together with an offer in IDLE
    offer(16, 8, 24, 3, 1'b0, 64'h55);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk_pass("F.p2", 18, 10, 26, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    chk("F.valid", 64'(uop_valid), 64'd0);
    chk("F.done", 64'(done), 64'd0);
    chk("F.in_ready", 64'(in_ready), 64'd1);
    offer(0, 0, 0, 0, 1'b0, 64'h66);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("F.no_accept", 64'(uop_valid), 64'd0);
    chk("F.no_illegal", 64'(illegal), 64'd0);
    tick();
    chk("F.no_done", 64'(done), 64'd0);
    chk("F.still_idle", 64'(uop_valid), 64'd0);

    // Reset mid-RUN during pass 1
    offer(4, 8, 12, 2, 1'b1, 64'h77);
    tick();
    in_valid = 1'b0;
    tick();
    chk("G.p1_idx", 64'(uop_idx), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("G.valid", 64'(uop_valid), 64'd0);
    chk("G.in_ready", 64'(in_ready), 64'd1);
    chk("G.idx", 64'(uop_idx), 64'd0);
    chk("G.vd", 64'(uop_vd), 64'd0);
    chk("G.vs1", 64'(uop_vs1), 64'd0);
    chk("G.vs2", 64'(uop_vs2), 64'd0);
    chk("G.ctrl", uop_ctrl, 64'd0);
    chk("G.flags", 64'({uop_first, uop_last, uop_acc_fwd, uop_wb_en, done, illegal}), 64'd0);
`ifdef RISCV_V_SEQ_PERF_EN
    chk("H.busy_rst", 64'(perf_busy_cnt), 64'd0);
    chk("H.stall_rst", 64'(perf_stall_cnt), 64'd0);
    offer(0, 4, 8, 2, 1'b0, 64'h88);
    tick();
    in_valid = 1'b0;
    for (int p = 0; p < 4; p++) tick();
    chk("H.done", 64'(done), 64'd1);
    chk("H.busy", 64'(perf_busy_cnt), 64'd4);
    chk("H.stall", 64'(perf_stall_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
